// File: rtl/ps2_rx_frame_pkg.sv
// Shared types and helpers for the PS/2 device-to-host frame receiver.
package ps2_pkg;

  // Start + 8 data + parity + stop.
  localparam int FRAME_BITS = 11;
  // Bits captured after the start bit: 8 data, parity, stop.
  localparam int SHIFT_BITS = FRAME_BITS - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_rx_frame_fifo.sv
// First-word fall-through circular byte buffer for received PS/2 bytes.
// A push and a pop in the same cycle are both honoured, even when full.
module ps2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // When full, a push is only legal if the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  // Head is forced to zero while empty so the output never shows stale storage.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointer and occupancy values.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage write port.
  // NOTE: storage is deliberately not reset; the occupancy count makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: glitch-filters ps2c, deserialises
// start/8 data/odd parity/stop frames, validates them, aborts stalled frames
// with a watchdog and buffers good bytes in a valid/ready FIFO.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       timeout_err
);

  localparam int CNT_W = $clog2(SHIFT_BITS);
  localparam int WD_W  = $clog2(TIMEOUT_CYC);

  logic [FILTER_LEN-1:0] filt_sh_q, filt_sh_d;
  logic                  f_reg_q, f_reg_d;
  logic                  f_next;
  logic                  fall;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [SHIFT_BITS-1:0] sh_q, sh_d;

  logic in_check, stop_ok, par_ok;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;

  // Glitch filter: the filtered level only moves once ps2c has been stable for FILTER_LEN samples.
  always_comb begin
    filt_sh_d = {filt_sh_q[FILTER_LEN-2:0], ps2c};
    if (&filt_sh_q)       f_next = 1'b1;
    else if (~|filt_sh_q) f_next = 1'b0;
    else                  f_next = f_reg_q;
    f_reg_d = f_next;
  end

  assign fall = f_reg_q & ~f_next;

  // Frame validation, evaluated only in the single CHECK cycle. Shift register
  // layout after 10 bits: [7:0] data LSB-first, [8] parity, [9] stop.
  assign in_check    = (state_q == CHECK);
  assign stop_ok     = sh_q[SHIFT_BITS-1];
  assign par_ok      = odd_parity_ok(sh_q[7:0], sh_q[8]);
  assign fifo_pop    = m_valid & m_ready;
  assign frame_err   = in_check & ~stop_ok;
  assign parity_err  = in_check & stop_ok & ~par_ok;
  // A full FIFO that is being drained this cycle still has room for the new byte.
  assign overrun     = in_check & stop_ok & par_ok & fifo_full & ~fifo_pop;
  assign fifo_push   = in_check & stop_ok & par_ok & (~fifo_full | fifo_pop);
  assign timeout_err = (state_q == SHIFT) & ~fall & (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign busy        = (state_q != IDLE);
  assign m_valid     = ~fifo_empty;

  // Receive FSM next-state, bit counter, watchdog and shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE: begin
        // A falling edge with ps2d high is a bad start bit and is silently ignored.
        if (fall && rx_en && !ps2d) begin
          cnt_d   = '0;
          wd_d    = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (fall) begin
          sh_d  = {ps2d, sh_q[SHIFT_BITS-1:1]};
          wd_d  = '0;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SHIFT_BITS - 1)) state_d = CHECK;
        end else if (timeout_err) begin
          // Partial frame is simply abandoned; the next start bit overwrites it.
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Filter, FSM and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_sh_q <= '0;
      f_reg_q   <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      wd_q      <= '0;
      sh_q      <= '0;
    end else begin
      filt_sh_q <= filt_sh_d;
      f_reg_q   <= f_reg_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      sh_q      <= sh_d;
    end
  end

  ps2_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (sh_q[7:0]),
    .pop       (fifo_pop),
    .head_data (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: directed scenarios with literal
// expectations plus randomized frames, all compared every cycle against a
// behavioural model built from run-length filtering and a bit/byte queue.
module tb_ps2_rx_frame;

  localparam int L = 4;    // FILTER_LEN
  localparam int D = 4;    // FIFO_DEPTH
  localparam int T = 100;  // TIMEOUT_CYC

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid, busy, parity_err, frame_err, overrun, timeout_err;

  ps2_rx_frame #(
    .FILTER_LEN  (L),
    .FIFO_DEPTH  (D),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .rx_en       (rx_en),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .busy        (busy),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Consumer handshake: random or fixed, applied shortly after each rising edge.
  bit rand_ready = 1'b0;
  bit ready_fix  = 1'b0;
  always @(posedge clk) begin
    #2;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  // ---------------- behavioural model ----------------
  bit         run_lvl;        // level of the current run of identical ps2c samples
  int         run_len;        // length of that run, saturating at L
  bit         flvl;           // filtered clock level
  bit         in_frame;
  bit         bits_q[$];      // bits captured after the start bit
  int         since;          // cycles since the last accepted falling edge
  logic [7:0] mq[$];          // expected FIFO contents

  task automatic model_reset();
    run_lvl  = 1'b0;
    run_len  = L;             // filter history starts as all zeros
    flvl     = 1'b0;
    in_frame = 1'b0;
    bits_q.delete();
    since    = 0;
    mq.delete();
  endtask

  // ---------------- observation of the DUT ----------------
  int         n_perr, n_ferr, n_ovr, n_tmo, n_vcyc;
  int         tmo_cyc, vrise_cyc;
  bit         busy_seen, prev_valid;
  logic [7:0] got[$];

  task automatic clear_obs();
    n_perr = 0; n_ferr = 0; n_ovr = 0; n_tmo = 0; n_vcyc = 0;
    tmo_cyc = -1; vrise_cyc = -1; busy_seen = 1'b0;
    got.delete();
  endtask

  task automatic check_got(input string name, input int n, input logic [63:0] exp);
    check({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      check($sformatf("%s_byte%0d", name, i), got[i], exp[8*i +: 8]);
  endtask

  // Per-cycle compare and model advance, away from the active edge.
  bit         m_cur, m_fall, m_chk, e_ferr, e_perr, e_ovr, e_push, e_tmo, e_valid;
  logic [7:0] m_d;
  always @(negedge clk) begin
    if (!reset_n) begin
      model_reset();
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_busy", busy, 0);
      check("rst_errs", {parity_err, frame_err, overrun, timeout_err}, 0);
    end else begin
      m_cur  = (run_len >= L) ? run_lvl : flvl;
      m_fall = flvl & ~m_cur;
      m_chk  = in_frame && (bits_q.size() == 10);
      e_ferr = 0; e_perr = 0; e_ovr = 0; e_push = 0; m_d = '0;
      if (m_chk) begin
        for (int i = 0; i < 8; i++) m_d[i] = bits_q[i];
        if (!bits_q[9]) e_ferr = 1;
        else if ((($countones(m_d) + int'(bits_q[8])) % 2) == 0) e_perr = 1;
        else if (mq.size() == D && !m_ready) e_ovr = 1;
        else e_push = 1;
      end
      e_tmo   = in_frame && !m_chk && !m_fall && (since == T);
      e_valid = (mq.size() > 0);

      check("m_valid", m_valid, e_valid);
      if (e_valid) check("m_data", m_data, mq[0]);
      check("busy", busy, in_frame);
      check("parity_err", parity_err, e_perr);
      check("frame_err", frame_err, e_ferr);
      check("overrun", overrun, e_ovr);
      check("timeout_err", timeout_err, e_tmo);

      if (e_valid && m_ready) void'(mq.pop_front());
      if (m_chk) begin
        if (e_push) mq.push_back(m_d);
        in_frame = 0;
        bits_q.delete();
      end else if (in_frame) begin
        if (m_fall) begin
          bits_q.push_back(ps2d);
          since = 1;
        end else if (e_tmo) begin
          in_frame = 0;
          bits_q.delete();
        end else begin
          since++;
        end
      end else if (m_fall && rx_en && !ps2d) begin
        in_frame = 1;
        bits_q.delete();
        since = 1;
      end
      flvl = m_cur;
      if (ps2c == run_lvl) begin
        if (run_len < L) run_len++;
      end else begin
        run_lvl = ps2c;
        run_len = 1;
      end
    end

    if (parity_err)  n_perr++;
    if (frame_err)   n_ferr++;
    if (overrun)     n_ovr++;
    if (timeout_err) begin n_tmo++; tmo_cyc = cyc; end
    if (m_valid) n_vcyc++;
    if (m_valid && !prev_valid) vrise_cyc = cyc;
    prev_valid = m_valid;
    if (busy) busy_seen = 1'b1;
    if (m_valid && m_ready) got.push_back(m_data);
  end

  // ---------------- stimulus helpers ----------------
  int last_drv;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^d) ^ bad_par;
    return {~bad_stop, p, d, 1'b0};
  endfunction

  // Device drives data while the clock is high; host samples on the falling edge.
  task automatic send_bits(input logic [10:0] b, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      ps2d = b[i];
      tick(half);
      ps2c = 1'b0;
      last_drv = cyc;
      tick(half);
      ps2c = 1'b1;
    end
    tick(half);
  endtask

  task automatic send_frame(input logic [10:0] b);
    send_bits(b, 11, 8);
  endtask

  initial begin
    int n;
    model_reset();
    clear_obs();
    prev_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_m_valid", m_valid, 0);
    check("post_rst_m_data", m_data, 0);
    check("post_rst_busy", busy, 0);
    tick(L + 4);

    // Valid 0x1C frame, consumer always ready.
    clear_obs();
    ready_fix = 1'b1;
    send_frame(11'b1_0_00011100_0);
    n = last_drv;
    tick(20);
    check_got("t1", 1, 64'h1C);
    check("t1_valid_cycles", n_vcyc, 1);
    check("t1_latency", vrise_cyc, n + L + 2);
    check("t1_errs", n_perr + n_ferr + n_ovr + n_tmo, 0);

    // Bad parity, then bad stop.
    clear_obs();
    send_frame(11'b1_1_00011100_0);
    tick(10);
    check("t2_parity_err", n_perr, 1);
    check("t2_valid_cycles", n_vcyc, 0);
    send_frame(11'b0_1_11111111_0);
    tick(10);
    check("t2_frame_err", n_ferr, 1);
    check("t2_parity_total", n_perr, 1);
    check("t2_got_count", got.size(), 0);

    // Overrun on the fifth byte with nobody draining.
    clear_obs();
    ready_fix = 1'b0;
    tick(1);
    for (int k = 1; k <= 4; k++) send_frame(make_frame(8'(k), 0, 0));
    check("t3_ovr_after4", n_ovr, 0);
    send_frame(make_frame(8'h05, 0, 0));
    check("t3_ovr_after5", n_ovr, 1);
    ready_fix = 1'b1;
    tick(20);
    check_got("t3", 4, 64'h04_03_02_01);

    // Full FIFO popped during the CHECK cycle of the fifth byte.
    clear_obs();
    ready_fix = 1'b0;
    tick(1);
    for (int k = 1; k <= 4; k++) send_frame(make_frame(8'(k), 0, 0));
    send_bits(make_frame(8'h05, 0, 0), 10, 8);
    ps2d = 1'b1;
    tick(8);
    ps2c = 1'b0;
    n = cyc;
    tick(L + 1);
    ready_fix = 1'b1;      // exactly the CHECK cycle
    tick(1);
    ready_fix = 1'b0;
    tick(8 - L - 2);
    ps2c = 1'b1;
    tick(8);
    check("t4_overrun", n_ovr, 0);
    check("t4_check_cycle", cyc > n + L + 1, 1);
    check_got("t4_first", 1, 64'h01);
    ready_fix = 1'b1;
    tick(20);
    check_got("t4", 5, 64'h05_04_03_02_01);

    // Watchdog: clock stops high after five bits.
    clear_obs();
    send_bits(make_frame(8'h5A, 0, 0), 5, 8);
    n = last_drv;
    tick(T + L + 20);
    check("t5_timeouts", n_tmo, 1);
    check("t5_timeout_cycle", tmo_cyc, n + L + T);
    check("t5_busy_after", busy, 0);
    send_frame(make_frame(8'hA5, 0, 0));
    tick(20);
    check_got("t5", 1, 64'hA5);
    check("t5_other_errs", n_perr + n_ferr + n_ovr, 0);

    // Short low glitch on ps2c with data low: must not start a frame.
    clear_obs();
    ps2d = 1'b0;
    ps2c = 1'b0;
    tick(L - 1);
    ps2c = 1'b1;
    tick(20);
    ps2d = 1'b1;
    check("t6_busy_seen", busy_seen, 0);

    // Receiver disabled for a whole frame.
    clear_obs();
    rx_en = 1'b0;
    send_frame(make_frame(8'h33, 0, 0));
    rx_en = 1'b1;
    tick(10);
    check("t7_busy_seen", busy_seen, 0);
    check("t7_got_count", got.size(), 0);

    // Reset in the middle of a frame with a byte buffered.
    clear_obs();
    ready_fix = 1'b0;
    send_frame(make_frame(8'h3C, 0, 0));
    @(negedge clk);
    check("t8_buffered", m_valid, 1);
    tick(1);
    send_bits(make_frame(8'h77, 0, 0), 5, 8);
    ps2c = 1'b0;
    tick(2);
    reset_n = 1'b0;
    @(negedge clk);
    check("t8_m_valid", m_valid, 0);
    check("t8_m_data", m_data, 0);
    check("t8_busy", busy, 0);
    check("t8_errs", {parity_err, frame_err, overrun, timeout_err}, 0);
    tick(3);
    ps2c = 1'b1;
    reset_n = 1'b1;
    ready_fix = 1'b1;
    tick(L + 10);
    check("t8_valid_after", m_valid, 0);
    check("t8_busy_after", busy, 0);
    send_frame(make_frame(8'h42, 0, 0));
    tick(20);
    check_got("t8", 1, 64'h42);

    // Randomized traffic against the model.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      logic [7:0] d;
      int half;
      d    = 8'($urandom);
      half = $urandom_range(6, 12);
      rx_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) begin
        send_bits(make_frame(d, 0, 0), $urandom_range(2, 9), half);
        tick(T + L + 5);
      end else begin
        send_bits(make_frame(d, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0), 11, half);
      end
      rx_en = 1'b1;
      tick($urandom_range(0, 15));
    end
    rand_ready = 1'b0;
    ready_fix  = 1'b1;
    tick(40);
    check("end_empty", m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run did not finish, limit 600000 ns");
    $fatal(1);
  end

endmodule

// File: doc/ps2_rx_frame.md
# ps2_rx_frame

Parametrised PS/2 device-to-host frame receiver. It filters the PS/2 clock and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). It checks start, parity and stop, and a watchdog aborts stalled frames. Good bytes are buffered in a small FIFO with a valid/ready output, so it sits between the PS/2 pins (after 2-FF synchronisers) and the keyboard/mouse decode logic.

## Interface
- FILTER_LEN, default 8: glitch-filter length in clk cycles; ps2c must be stable this long to change the filtered level (≥2).
- FIFO_DEPTH, default 4: byte FIFO entries (power of 2, ≥2).
- TIMEOUT_CYC, default 5000: clk cycles without a filtered falling edge before an in-progress frame is aborted.
- clk, in, 1: system clock. Single clock domain.
- reset_n, in, 1: asynchronous, active-low reset.
- ps2c, in, 1: synchronised PS/2 clock.
- ps2d, in, 1: synchronised PS/2 data.
- rx_en, in, 1: enables acceptance of a new start bit. It has no effect on a frame already in progress.
- m_data, out, 8: head-of-FIFO byte.
- m_valid, out, 1: FIFO non-empty.
- m_ready, in, 1: consumer pops when m_valid & m_ready.
- busy, out, 1: high in SHIFT or CHECK.
- parity_err, out, 1: one-cycle pulse when a frame is dropped for bad parity.
- frame_err, out, 1: one-cycle pulse when a frame is dropped for stop bit = 0.
- overrun, out, 1: one-cycle pulse when a good frame is dropped because the FIFO is full.
- timeout_err, out, 1: one-cycle pulse when the watchdog aborts a frame.

## Operation
- Filter
  - filt_sh (FILTER_LEN bits) shifts in ps2c every cycle.
  - f_next = 1 if filt_sh is all ones, 0 if it is all zeros, otherwise it holds f_reg.
  - fall = f_reg & ~f_next.
- State IDLE
  - On fall & rx_en with ps2d = 0: clear the bit counter and the watchdog, then go to SHIFT.
  - On fall with ps2d = 1 (bad start bit): stay in IDLE. No error is flagged.
- State SHIFT
  - On each fall: shift ps2d into a 10-bit shift register from the MSB end, reset the watchdog, and increment the counter.
  - The 10th bit (stop) moves the FSM to CHECK.
  - With no fall, the watchdog increments. When it reaches TIMEOUT_CYC-1, pulse timeout_err, go to IDLE, and discard the partial frame.
- State CHECK (exactly one cycle), then IDLE. Decisions in priority order:
  - stop = 0: pulse frame_err.
  - XOR of data and parity = 0: pulse parity_err.
  - FIFO full and not popping this cycle: pulse overrun.
  - Otherwise push the data byte.
  - Errors are mutually exclusive per frame.
- Simultaneous pop and push while the FIFO is full: both take effect and the count is unchanged. This is not an overrun.
- FIFO is first-word fall-through. m_data is valid whenever m_valid = 1 and is held stable until the pop.
- Counter and watchdog widths: $clog2(10) and $clog2(TIMEOUT_CYC). No wrap: the watchdog saturates by design via the abort.

## Timing
- Reset values:
  - FSM = IDLE; filt_sh, f_reg, counter, watchdog and shift register = 0; FIFO empty.
  - Outputs: m_valid = 0, m_data = 0, busy = 0, all error pulses = 0.
- A ps2c transition is seen by fall at most FILTER_LEN cycles after it settles.
- Latency: the stop bit is sampled on clock edge E. CHECK is active in the cycle after E, the push occurs at the end of that CHECK cycle, and m_valid = 1 two cycles after E (FIFO previously empty).
- Error and overrun pulses are asserted during the CHECK cycle.
- A pop is accepted on the edge where m_valid & m_ready. The next entry (or m_valid = 0) appears in the following cycle.
- reset_n asserted mid-frame aborts immediately. No error pulse is generated, and FIFO contents are lost.

## Structure
- Package ps2_pkg holds:
  - the state enum (IDLE, SHIFT, CHECK);
  - localparam FRAME_BITS = 11;
  - the odd-parity check function.
- Sub-module ps2_rx_fifo(WIDTH, DEPTH): FWFT circular buffer with push/pop/full/empty and the same clk/reset_n.
- Filter, FSM and watchdog live in the top module.

## Test plan
- Valid frame: bits 0, 0,0,1,1,1,0,0,0, 0, 1 (byte 0x1C, m_ready = 1) → m_data = 0x1C, m_valid for exactly 1 cycle, and 2-cycle latency from the stop edge; no error pulses.
- Same frame with parity bit 1 → parity_err pulse, m_valid stays 0. Frame 0xFF with stop = 0 → frame_err pulse, no push.
- m_ready = 0, send 0x01..0x05 → overrun once on the 5th byte. Draining then yields 0x01..0x04 in order.
- FIFO full with m_ready = 1 during the CHECK of the 5th byte → no overrun, and 0x02..0x05 remain.
- ps2c held high after 5 bits → timeout_err exactly TIMEOUT_CYC cycles after the last fall. A following 0xA5 frame is received correctly.
- ps2c low glitch of FILTER_LEN-1 cycles → no bit accepted. rx_en = 0 at the start bit → frame ignored. reset_n pulse mid-frame → all outputs return to reset values.
